// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: XLEN, reset PC, the IF/ID bubble encoding,
// the prefetch-queue entry layout and the PC helpers.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0,x0,0 - what IF/ID latches when if_valid is low
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer of {pc, inst} with push, pop and flush.
// Latency: a push is visible at the head the following cycle.
// Backpressure: none internally; the owner must never push when full or pop when empty.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_dat,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

    assert property (@(posedge clk) disable iff (!rst) !(push && !pop && count == CW'(DEPTH)));
    assert property (@(posedge clk) disable iff (!rst) !(pop && count == '0));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues sequential word fetches and queues returned {pc, inst} for IF/ID.
// Latency: response in cycle N is at the queue head in N+1; redirect at R gives a new-path request in R+1.
// Backpressure: requests stop once queued + outstanding would exceed DEPTH; the queue holds while if_ready is low.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    input  logic            if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [SW-1:0]   inflight;
    logic            req_fire;
    logic            rsp_ok;
    logic            drop_rsp;
    logic            push;
    logic            pop;
    fetch_entry_t    push_dat;
    fetch_entry_t    head;

    assign pop      = if_valid && if_ready && !redirect;
    assign inflight = SW'(q_count) + SW'(outstanding) - SW'(pop);

    // Gated by rst so the request line is quiet while reset is held
    assign imem_req_valid = rst && !redirect && (inflight < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
    assign drop_rsp = (drop_cnt != '0);
    assign push     = rsp_ok && !drop_rsp && !redirect;
    assign push_dat = '{pc: rsp_pc, inst: imem_rsp_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
            if (redirect) begin
                fetch_pc <= align_pc(redirect_pc);
                rsp_pc   <= align_pc(redirect_pc);
                // Pending drops are a subset of outstanding, so existing drops plus the
                // live requests is just what stays outstanding; bounded by DEPTH
                drop_cnt <= outstanding - CW'(rsp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= next_pc(fetch_pc);
                end
                if (push) begin
                    rsp_pc <= next_pc(rsp_pc);
                end
                if (rsp_ok && drop_rsp) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (head),
        .count    (q_count)
    );

    assign if_valid = (q_count != '0);
    assign if_pc    = head.pc;
    assign if_inst  = head.inst;

    assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined CPU. It generates sequential fetch addresses, issues them to a variable-latency instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small prefetch queue. The queue drains into the IF/ID pipeline register under a ready/valid handshake. A redirect from the branch/jump resolution logic flushes the queue and discards in-flight responses.

## Interface
Parameters:
- DEPTH, 4: prefetch queue entries and maximum outstanding memory requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, word-aligned.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  instruction word returned this cycle; responses arrive in request order.
- imem_rsp_data  in  32  returned instruction.
- redirect  in  1  taken jal/jalr/branch; flush and refetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- if_valid  out  1  queue head holds a valid instruction.
- if_pc  out  32  PC of the head entry.
- if_inst  out  32  instruction of the head entry.
- if_ready  in  1  IF/ID accepts the head entry (low = decode stall).

## Operation
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next accepted response.
  - outstanding: 0..DEPTH.
  - drop_cnt: 0..DEPTH.
  - queue: count 0..DEPTH.
- Request issue:
  - imem_req_valid = !redirect && (count + outstanding − (pop this cycle) < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid & ready): fetch_pc += 4 and outstanding += 1.
- Response:
  - On imem_rsp_valid, outstanding −= 1.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push {rsp_pc, imem_rsp_data} into the queue and set rsp_pc += 4.
- Pop: if_valid = (count ≠ 0). The head is popped when if_valid & if_ready.
- Redirect (highest priority):
  - Queue is cleared and any pop that cycle is cancelled.
  - fetch_pc and rsp_pc are loaded with {redirect_pc[31:2], 2'b00}.
  - drop_cnt is loaded with the number of requests still outstanding after this cycle's response is counted. Any response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
- A redirect while drop_cnt > 0 adds the current outstanding requests to the drops; drop_cnt never exceeds DEPTH.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Full: no request is issued, so a push into a full queue cannot occur; a push and a pop in the same cycle are both allowed.
- Empty: if_valid = 0, if_pc and if_inst hold the last head value (don't-care to consumers).
- An imem_rsp_valid with outstanding = 0 is a protocol violation; it is ignored and flagged by an assertion.

## Timing
- Reset values:
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - if_valid = 0, if_pc = 0, if_inst = 0.
  - All counters 0.
- Reset mid-operation clears everything immediately; in-flight responses are the memory's responsibility to squash.
- First request: the first rising edge after rst deasserts (cycle 0).
- Latency: a response at cycle N appears at the queue head with if_valid = 1 in cycle N+1. With a 1-cycle memory: request at cycle 0, response at cycle 1, if_valid at cycle 2.
- Throughput: 1 instruction/cycle sustained when memory latency < DEPTH and if_ready = 1.
- Redirect at cycle R: if_valid = 0 in R+1; new-path request issued in R+1.

## Structure
- Shared package:
  - XLEN = 32.
  - RESET_PC default.
  - NOP encoding 32'h0000_0013 (addi x0,x0,0), used by IF/ID when if_valid = 0.
- One natural sub-module: fetch_fifo. It is a DEPTH×64 circular buffer with push, pop, flush and count, using pointer wrap at DEPTH and a separate count for full/empty.

## Test plan
- Zero-stall run: RESET_PC = 0, memory returns 1 cycle after accept, if_ready = 1. Required: if_pc = 0, 4, 8, 12 on consecutive cycles from cycle 2; each if_inst matches memory.
- Backpressure: hold if_ready = 0 for 10 cycles with DEPTH = 4. Required: exactly 4 requests issued and count = 4; on release, PCs 0..12 emerge in order with no duplicates.
- Redirect with in-flight: 3-cycle memory latency, 3 requests outstanding, redirect_pc = 32'h100. Required: all 3 old responses are dropped; the next if_pc is 32'h100.
- Redirect with unaligned target: redirect_pc = 32'h203. Required: imem_req_addr = 32'h200 next cycle.
- Wrap: redirect_pc = 32'hFFFF_FFF8. Required: if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream: assert rst low between edges. Required: if_valid and imem_req_valid drop to 0 immediately; after release, fetch restarts at RESET_PC.
